tx_initiated_point_test_rx: RTL and testbench
=============================================

# tx_initiated_point_test_rx

Responder half of the TX-initiated point test, on the partner die of the point-test requester. Decodes the requester's sideband requests (start, LFSR clear, result, end) and answers each with the matching response. Drives the mainband/valid comparators for the duration of the pattern burst, and returns per-lane pass/fail results on the sideband. Sits between the sideband RX/TX message mux and the pattern comparators, and reports completion to the LTSM.

## Interface
Parameters:
- NUM_LANES, 16, mainband lanes reported in the result response (fixed to the sideband data width).

Ports:
- clk  in  1  block clock
- rst  in  1  synchronous, active-high reset
- i_en  in  1  LTSM enable; low forces IDLE from any state
- i_lfsr_or_perlane  in  1  0 = LFSR comparison, 1 = per-lane-ID comparison
- i_sideband_message  in  4  decoded incoming request code
- i_sideband_data  in  16  incoming request data
- i_sideband_message_valid  in  1  one-cycle strobe qualifying message/data
- i_busy_negedge_detected  in  1  sideband serializer finished a message
- i_valid_tx  in  1  requester-side block on this die is driving the sideband
- i_lane_result  in  16  live per-lane pass flags from the mainband comparator
- i_val_result  in  1  live pass flag from the valid-lane comparator
- o_sideband_message  out  4  response code
- o_sideband_data  out  16  response data
- o_valid_tx  out  1  response pending
- o_data_valid  out  1  o_sideband_data meaningful
- o_comparator_clear  out  1  one-cycle LFSR/error-counter clear
- o_mainband_comparator_cw  out  2  00 off, 10 LFSR, 11 per-lane ID
- o_val_comparator_en  out  1  valid-pattern comparator enable
- o_lane_result  out  16  result latched at result request
- o_test_ack_rx  out  1  test complete, held until i_en low

## Operation
Request/response codes:
- start 0001/0010
- clear 0011/0100
- result 0101/0110
- end 0111/1000

Start request data fields:
- bit0 = pattern (0 mainband, 1 valtrain)
- bit4 = burst count
- bit5 = comparison mode

State sequence:
- IDLE: on i_en, go to WAIT_START.
- WAIT_START: on start request, latch bit0 as `valtrain`, send 0010, go to WAIT_CLEAR.
- WAIT_CLEAR: on clear request, pulse o_comparator_clear, send 0100, go to COMPARE.
  - Comparator enable per mode: valtrain gives o_val_comparator_en=1. Otherwise cw = i_lfsr_or_perlane ? 11 : 10.
- COMPARE: on result request, set cw=00 and val_en=0, then latch the result:
  - o_lane_result = valtrain ? {15'h0, i_val_result} : i_lane_result.
  - Drive o_sideband_data = that value and o_data_valid=1, send 0110, go to WAIT_END.
- WAIT_END: on end request, send 1000, set o_test_ack_rx=1, go to FINISHED.
- FINISHED: hold until i_en low, then IDLE.

Message handling:
- A request is accepted only when i_sideband_message_valid is high and the code matches the current state.
- Any other code, or a valid strobe in IDLE/FINISHED, is ignored.
- i_en low in any state:
  - next cycle, state goes to IDLE;
  - all outputs return to reset values, including o_valid_tx and the comparator controls.

## Timing
- Reset values: every output 0; cw = 00; state IDLE.
- Accepted request at cycle N: at N+1, o_sideband_message holds the response code, o_valid_tx=1 and the comparator controls update.
- o_comparator_clear is high exactly at cycle N+1.
- o_valid_tx stays high until a cycle with i_busy_negedge_detected=1 and i_valid_tx=0; it clears on the following edge.
  - When i_valid_tx=1, the busy negedge belongs to the other block and is ignored.
- o_data_valid follows the same clear rule. It is set only with the 0110 response.
- o_sideband_data holds its value until the next 0110 response or IDLE.
- An accepted request while o_valid_tx is still high:
  - the new response overwrites the old one;
  - o_valid_tx stays high with no gap.
- Reset mid-test and i_en low with a request strobe in the same cycle: reset/IDLE wins and the request is dropped.
- o_lane_result samples i_lane_result/i_val_result on the same edge the comparator is disabled. The comparator pipeline is expected to be settled before the requester sends the result request.

## Structure
- Shared point-test package: the 4-bit request/response code constants, the state encoding, and the start-data bit positions (pattern=0, burst=4, compare=5). The requester side uses the same package.
- Single module, no sub-modules. Next-state logic is combinational; outputs are registered from the (cs, ns) pair.

## Test plan
- Mainband LFSR flow:
  - stimulus: i_en=1, i_lfsr_or_perlane=0; requests 0001 (data 0x0000), 0011, 0101 with i_lane_result=0xFFF0, then 0111;
  - required: responses 0010/0100/0110/1000 in order; cw=10 between clear and result; 0110 data 0xFFF0; o_test_ack_rx=1 after 1000.
- Valtrain flow:
  - stimulus: start data 0x0011, i_val_result=1;
  - required: o_val_comparator_en=1 and cw=00 while comparing; 0110 data 0x0001; o_lane_result=0x0001.
- Valid handshake:
  - stimulus: busy negedge with i_valid_tx=1;
  - required: o_valid_tx stays 1; a later busy negedge with i_valid_tx=0 clears o_valid_tx and o_data_valid the next cycle.
- Out-of-order request:
  - stimulus: 0101 while in WAIT_CLEAR;
  - required: no response and state unchanged; a subsequent 0011 gives 0100 plus a one-cycle o_comparator_clear.
- Abort:
  - stimulus: i_en dropped during COMPARE with cw=11;
  - required: next cycle all outputs are 0; re-enabling restarts from WAIT_START.
- Reset:
  - stimulus: rst asserted during WAIT_END with o_valid_tx=1;
  - required: all outputs 0 after the edge; an end request arriving in the same cycle is ignored.

Source files
------------

// File: rtl/tx_initiated_point_test_rx_pkg.sv
// rtl/tx_initiated_point_test_rx_pkg.sv - shared point-test codes, states and start-data fields
package tx_initiated_point_test_rx_pkg;

  localparam logic [3:0] MSG_START_REQ   = 4'b0001;
  localparam logic [3:0] MSG_START_RESP  = 4'b0010;
  localparam logic [3:0] MSG_CLEAR_REQ   = 4'b0011;
  localparam logic [3:0] MSG_CLEAR_RESP  = 4'b0100;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'b0101;
  localparam logic [3:0] MSG_RESULT_RESP = 4'b0110;
  localparam logic [3:0] MSG_END_REQ     = 4'b0111;
  localparam logic [3:0] MSG_END_RESP    = 4'b1000;

  localparam int START_BIT_PATTERN = 0;
  localparam int START_BIT_BURST   = 4;
  localparam int START_BIT_COMPARE = 5;

  localparam logic [1:0] CW_OFF     = 2'b00;
  localparam logic [1:0] CW_LFSR    = 2'b10;
  localparam logic [1:0] CW_PERLANE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_WAIT_CLEAR,
    ST_COMPARE,
    ST_WAIT_END,
    ST_FINISHED
  } state_t;

endpackage

// File: rtl/tx_initiated_point_test_rx.sv
// rtl/tx_initiated_point_test_rx.sv - point-test responder: answers sideband requests, drives comparators
module tx_initiated_point_test_rx
  import tx_initiated_point_test_rx_pkg::*;
#(
  parameter int NUM_LANES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_lfsr_or_perlane,
  input  logic [3:0]           i_sideband_message,
  input  logic [NUM_LANES-1:0] i_sideband_data,
  input  logic                 i_sideband_message_valid,
  input  logic                 i_busy_negedge_detected,
  input  logic                 i_valid_tx,
  input  logic [NUM_LANES-1:0] i_lane_result,
  input  logic                 i_val_result,
  output logic [3:0]           o_sideband_message,
  output logic [NUM_LANES-1:0] o_sideband_data,
  output logic                 o_valid_tx,
  output logic                 o_data_valid,
  output logic                 o_comparator_clear,
  output logic [1:0]           o_mainband_comparator_cw,
  output logic                 o_val_comparator_en,
  output logic [NUM_LANES-1:0] o_lane_result,
  output logic                 o_test_ack_rx
);

  state_t               r_cs;
  state_t               w_ns;
  logic                 w_accept;
  logic                 r_valtrain;
  logic [NUM_LANES-1:0] w_result;
  logic                 w_unused_start_fields;

  // Burst count and compare-mode fields are carried for the requester; this side does not act on them.
  assign w_unused_start_fields = ^i_sideband_data[NUM_LANES-1:1];

  assign w_result = r_valtrain ? {{(NUM_LANES-1){1'b0}}, i_val_result} : i_lane_result;

  always_comb begin
    w_ns     = r_cs;
    w_accept = 1'b0;
    case (r_cs)
      ST_IDLE:       w_ns = ST_WAIT_START;
      ST_WAIT_START: w_accept = i_sideband_message_valid && (i_sideband_message == MSG_START_REQ);
      ST_WAIT_CLEAR: w_accept = i_sideband_message_valid && (i_sideband_message == MSG_CLEAR_REQ);
      ST_COMPARE:    w_accept = i_sideband_message_valid && (i_sideband_message == MSG_RESULT_REQ);
      ST_WAIT_END:   w_accept = i_sideband_message_valid && (i_sideband_message == MSG_END_REQ);
      ST_FINISHED:   w_ns = ST_FINISHED;
      default:       w_ns = ST_IDLE;
    endcase
    if (w_accept) begin
      case (r_cs)
        ST_WAIT_START: w_ns = ST_WAIT_CLEAR;
        ST_WAIT_CLEAR: w_ns = ST_COMPARE;
        ST_COMPARE:    w_ns = ST_WAIT_END;
        default:       w_ns = ST_FINISHED;
      endcase
    end
    if (!i_en) begin
      w_ns     = ST_IDLE;
      w_accept = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cs                     <= ST_IDLE;
      r_valtrain               <= 1'b0;
      o_sideband_message       <= 4'b0000;
      o_sideband_data          <= '0;
      o_valid_tx               <= 1'b0;
      o_data_valid             <= 1'b0;
      o_comparator_clear       <= 1'b0;
      o_mainband_comparator_cw <= CW_OFF;
      o_val_comparator_en      <= 1'b0;
      o_lane_result            <= '0;
      o_test_ack_rx            <= 1'b0;
    end else begin
      r_cs               <= w_ns;
      o_comparator_clear <= 1'b0;
      if (w_accept) begin
        // A new response overwrites any pending one; valid stays high without a gap.
        o_valid_tx   <= 1'b1;
        o_data_valid <= 1'b0;
        case (r_cs)
          ST_WAIT_START: begin
            o_sideband_message <= MSG_START_RESP;
            r_valtrain         <= i_sideband_data[START_BIT_PATTERN];
          end
          ST_WAIT_CLEAR: begin
            o_sideband_message <= MSG_CLEAR_RESP;
            o_comparator_clear <= 1'b1;
            if (r_valtrain) begin
              o_val_comparator_en      <= 1'b1;
              o_mainband_comparator_cw <= CW_OFF;
            end else begin
              o_mainband_comparator_cw <= i_lfsr_or_perlane ? CW_PERLANE : CW_LFSR;
            end
          end
          ST_COMPARE: begin
            o_sideband_message       <= MSG_RESULT_RESP;
            o_mainband_comparator_cw <= CW_OFF;
            o_val_comparator_en      <= 1'b0;
            o_lane_result            <= w_result;
            o_sideband_data          <= w_result;
            o_data_valid             <= 1'b1;
          end
          ST_WAIT_END: begin
            o_sideband_message <= MSG_END_RESP;
            o_test_ack_rx      <= 1'b1;
          end
          default: ;
        endcase
      end else if (i_busy_negedge_detected && !i_valid_tx) begin
        // Busy negedge only counts when our own response was on the wire.
        o_valid_tx   <= 1'b0;
        o_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_initiated_point_test_rx.sv
// tb/tb_tx_initiated_point_test_rx.sv - randomized bench with behavioural model for the point-test responder
module tb_tx_initiated_point_test_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        perlane;
  logic [3:0]  sb_msg;
  logic [15:0] sb_data;
  logic        sb_valid;
  logic        busy;
  logic        vtx_in;
  logic [15:0] lane;
  logic        val_res;

  logic [3:0]  o_msg;
  logic [15:0] o_data;
  logic        o_vtx;
  logic        o_dv;
  logic        o_clr;
  logic [1:0]  o_cw;
  logic        o_val_en;
  logic [15:0] o_lr;
  logic        o_ack;

  always #5 clk = ~clk;

  tx_initiated_point_test_rx #(.NUM_LANES(16)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .i_en                     (en),
    .i_lfsr_or_perlane        (perlane),
    .i_sideband_message       (sb_msg),
    .i_sideband_data          (sb_data),
    .i_sideband_message_valid (sb_valid),
    .i_busy_negedge_detected  (busy),
    .i_valid_tx               (vtx_in),
    .i_lane_result            (lane),
    .i_val_result             (val_res),
    .o_sideband_message       (o_msg),
    .o_sideband_data          (o_data),
    .o_valid_tx               (o_vtx),
    .o_data_valid             (o_dv),
    .o_comparator_clear       (o_clr),
    .o_mainband_comparator_cw (o_cw),
    .o_val_comparator_en      (o_val_en),
    .o_lane_result            (o_lr),
    .o_test_ack_rx            (o_ack)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: p counts handshake progress (0 idle, 1..4 awaiting request 2p-1, 5 finished).
  int          p = 0;
  logic [3:0]  m_msg = '0;
  logic [15:0] m_data = '0, m_lr = '0;
  logic        m_vtx = 0, m_dv = 0, m_clr = 0, m_val_en = 0, m_ack = 0, m_valtrain = 0;
  logic [1:0]  m_cw = '0;

  always @(posedge clk) begin : model
    logic acc;
    if (rst || !en) begin
      p = 0; m_msg = '0; m_data = '0; m_lr = '0; m_vtx = 0; m_dv = 0;
      m_clr = 0; m_val_en = 0; m_ack = 0; m_valtrain = 0; m_cw = '0;
    end else begin
      m_clr = 0;
      acc = sb_valid && (p >= 1) && (p <= 4) && (sb_msg == 4'(2 * p - 1));
      if (p == 0) begin
        p = 1;
      end else if (acc) begin
        m_msg = sb_msg + 4'd1;
        m_vtx = 1;
        m_dv  = (p == 3);
        if (p == 1) begin
          m_valtrain = sb_data[0];
        end else if (p == 2) begin
          m_clr    = 1;
          m_val_en = m_valtrain;
          m_cw     = m_valtrain ? 2'b00 : (perlane ? 2'b11 : 2'b10);
        end else if (p == 3) begin
          m_cw     = 2'b00;
          m_val_en = 0;
          m_lr     = m_valtrain ? 16'(val_res) : lane;
          m_data   = m_lr;
        end else begin
          m_ack = 1;
        end
        p++;
      end else if (busy && !vtx_in) begin
        m_vtx = 0;
        m_dv  = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m.msg",    32'(o_msg),    32'(m_msg));
      check("m.data",   32'(o_data),   32'(m_data));
      check("m.vtx",    32'(o_vtx),    32'(m_vtx));
      check("m.dv",     32'(o_dv),     32'(m_dv));
      check("m.clr",    32'(o_clr),    32'(m_clr));
      check("m.cw",     32'(o_cw),     32'(m_cw));
      check("m.val_en", 32'(o_val_en), 32'(m_val_en));
      check("m.lr",     32'(o_lr),     32'(m_lr));
      check("m.ack",    32'(o_ack),    32'(m_ack));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] m, input logic [15:0] d);
    sb_valid = 1'b1; sb_msg = m; sb_data = d;
    tick();
    sb_valid = 1'b0;
  endtask

  task automatic restart();
    en = 1'b0; tick();
    en = 1'b1; tick();
  endtask

  initial begin
    rst = 1; en = 0; perlane = 0; sb_msg = 0; sb_data = 0; sb_valid = 0;
    busy = 0; vtx_in = 0; lane = 0; val_res = 0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst.msg", 32'(o_msg), 32'h0);
    check("rst.vtx", 32'(o_vtx), 32'h0);
    check("rst.cw",  32'(o_cw),  32'h0);
    check("rst.ack", 32'(o_ack), 32'h0);
    rst = 0;

    en = 1; tick();
    send(4'b0001, 16'h0000);
    check("lfsr.start_resp", 32'(o_msg), 32'h2);
    check("lfsr.start_vtx",  32'(o_vtx), 32'h1);
    send(4'b0011, 16'h0000);
    check("lfsr.clear_resp", 32'(o_msg), 32'h4);
    check("lfsr.clr_pulse",  32'(o_clr), 32'h1);
    check("lfsr.cw",         32'(o_cw),  32'h2);
    tick();
    check("lfsr.clr_one",    32'(o_clr), 32'h0);
    check("lfsr.cw_hold",    32'(o_cw),  32'h2);
    lane = 16'hFFF0;
    send(4'b0101, 16'h0000);
    check("lfsr.result_resp", 32'(o_msg),  32'h6);
    check("lfsr.result_data", 32'(o_data), 32'hFFF0);
    check("lfsr.result_dv",   32'(o_dv),   32'h1);
    check("lfsr.cw_off",      32'(o_cw),   32'h0);

    busy = 1; vtx_in = 1; tick();
    check("hs.other_vtx", 32'(o_vtx), 32'h1);
    check("hs.other_dv",  32'(o_dv),  32'h1);
    vtx_in = 0; tick();
    check("hs.own_vtx", 32'(o_vtx), 32'h0);
    check("hs.own_dv",  32'(o_dv),  32'h0);
    check("hs.data_hold", 32'(o_data), 32'hFFF0);
    busy = 0;

    send(4'b0111, 16'h0000);
    check("lfsr.end_resp", 32'(o_msg), 32'h8);
    check("lfsr.ack",      32'(o_ack), 32'h1);
    tick();
    check("lfsr.ack_hold", 32'(o_ack), 32'h1);

    restart();
    send(4'b0001, 16'h0011);
    send(4'b0011, 16'h0000);
    check("vt.val_en", 32'(o_val_en), 32'h1);
    check("vt.cw",     32'(o_cw),     32'h0);
    val_res = 1; lane = 16'hABCD;
    send(4'b0101, 16'h0000);
    check("vt.data", 32'(o_data),   32'h0001);
    check("vt.lr",   32'(o_lr),     32'h0001);
    check("vt.off",  32'(o_val_en), 32'h0);
    send(4'b0111, 16'h0000);

    restart();
    perlane = 1;
    send(4'b0001, 16'h0000);
    send(4'b0101, 16'h0000);
    check("ooo.no_resp", 32'(o_msg), 32'h2);
    check("ooo.no_clr",  32'(o_clr), 32'h0);
    send(4'b0011, 16'h0000);
    check("ooo.clear_resp", 32'(o_msg), 32'h4);
    check("ooo.clr_pulse",  32'(o_clr), 32'h1);
    check("abort.cw_pl",    32'(o_cw),  32'h3);
    tick();
    check("ooo.clr_one", 32'(o_clr), 32'h0);

    en = 0; tick();
    check("abort.cw",  32'(o_cw),  32'h0);
    check("abort.vtx", 32'(o_vtx), 32'h0);
    check("abort.msg", 32'(o_msg), 32'h0);
    en = 1; tick();
    send(4'b0001, 16'h0000);
    check("abort.restart", 32'(o_msg), 32'h2);

    send(4'b0011, 16'h0000);
    send(4'b0101, 16'h0000);
    rst = 1; sb_valid = 1; sb_msg = 4'b0111;
    tick();
    rst = 0; sb_valid = 0;
    check("rst.mid_vtx", 32'(o_vtx), 32'h0);
    check("rst.mid_ack", 32'(o_ack), 32'h0);
    check("rst.mid_msg", 32'(o_msg), 32'h0);
    check("rst.mid_dv",  32'(o_dv),  32'h0);
    tick();
    check("rst.no_ack", 32'(o_ack), 32'h0);

    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      en       = ($urandom_range(0, 199) != 0);
      perlane  = 1'($urandom);
      sb_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0 && p >= 1 && p <= 4)
        sb_msg = 4'(2 * p - 1);
      else
        sb_msg = 4'($urandom);
      sb_data = 16'($urandom);
      busy    = ($urandom_range(0, 3) == 0);
      vtx_in  = 1'($urandom);
      lane    = 16'($urandom);
      val_res = 1'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
